// File: rtl/ea_capture_pkg.sv
// Shared types for the error-analyzer sample capture path: record layout,
// capture FSM states and fixed counter widths.
package ea_capture_pkg;

   localparam int EA_DATA_W  = 32;
   localparam int EA_TIME_W  = 64;
   localparam int EA_SEQ_W   = 16;
   localparam int EA_DEPTH   = 16;
   localparam int DROP_CNT_W = 16;

   typedef struct packed {
      logic [EA_DATA_W-1:0] read;
      logic [EA_DATA_W-1:0] exp;
      logic [EA_TIME_W-1:0] time_stamp;
      logic [EA_SEQ_W-1:0]  seq;
      logic                 mismatch;
   } ea_sample_t;

   localparam int SMP_W = $bits(ea_sample_t);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2
   } ea_cap_state_e;

endpackage

// File: rtl/ea_sample_fifo.sv
// First-word-fall-through FIFO of packed sample records. A push into a full
// FIFO is accepted only when a pop frees a slot in the same cycle.
module ea_sample_fifo
   import ea_capture_pkg::*;
#(
   parameter int DEPTH = EA_DEPTH
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     push,
   input  logic                     pop,
   input  logic [SMP_W-1:0]         wdata,
   output logic [SMP_W-1:0]         rdata,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   level
);

   localparam int AW = $clog2(DEPTH);

   logic [SMP_W-1:0] mem_q [DEPTH];
   logic [SMP_W-1:0] mem_d [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [AW:0]      count_q, count_d;
   logic             do_push, do_pop;

   assign empty   = (count_q == '0);
   assign full    = (count_q == (AW+1)'(DEPTH));
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign rdata   = mem_q[rd_ptr_q];
   assign level   = count_q;

   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (do_push) begin
         mem_d[wr_ptr_q] = wdata;
         wr_ptr_d        = wr_ptr_q + 1'b1;
      end
      if (do_pop) begin
         rd_ptr_d = rd_ptr_q + 1'b1;
      end
      case ({do_push, do_pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   // Storage is cleared on reset so the head presents zeros afterwards.
   always_ff @(posedge clk) begin
      if (reset) begin
         mem_q    <= '{default: '0};
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

endmodule

// File: rtl/ea_sample_capture.sv
// Captures read/expected pairs with timestamp and sequence number, buffers them
// and streams them out; EA_CAPTURE_MISMATCH_ONLY_EN keeps only mismatching pairs.
module ea_sample_capture
   import ea_capture_pkg::*;
#(
   parameter int DATA_W = EA_DATA_W,
   parameter int TIME_W = EA_TIME_W,
   parameter int DEPTH  = EA_DEPTH,
   parameter int SEQ_W  = EA_SEQ_W
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    en,
   input  logic                    smp_valid,
   input  logic [DATA_W-1:0]       smp_read,
   input  logic [DATA_W-1:0]       smp_exp,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [DATA_W-1:0]       out_read,
   output logic [DATA_W-1:0]       out_exp,
   output logic [TIME_W-1:0]       out_time,
   output logic [SEQ_W-1:0]        out_seq,
   output logic                    out_mismatch,
   output logic [$clog2(DEPTH):0]  level,
   output logic                    overflow,
   output logic [DROP_CNT_W-1:0]   drop_cnt,
   output logic                    done
);

   ea_cap_state_e         state_q, state_d;
   logic [TIME_W-1:0]     time_q, time_d;
   logic [SEQ_W-1:0]      seq_q, seq_d;
   logic                  overflow_q, overflow_d;
   logic [DROP_CNT_W-1:0] drop_cnt_q, drop_cnt_d;

   logic       honour, smp_mismatch, push_req, pop, drop;
   logic       fifo_full, fifo_empty;
   ea_sample_t wr_rec, rd_rec;

   assign smp_mismatch = (smp_read != smp_exp);
   assign honour       = (state_q == RUN) && smp_valid;
`ifdef EA_CAPTURE_MISMATCH_ONLY_EN
   assign push_req     = honour && smp_mismatch;
`else
   assign push_req     = honour;
`endif
   assign pop          = out_valid && out_ready;
   assign drop         = push_req && fifo_full && !pop;

   always_comb begin
      wr_rec            = '0;
      wr_rec.read       = smp_read;
      wr_rec.exp        = smp_exp;
      wr_rec.time_stamp = time_q;
      wr_rec.seq        = seq_q;
      wr_rec.mismatch   = smp_mismatch;
   end

   ea_sample_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (push_req),
      .pop   (pop),
      .wdata (wr_rec),
      .rdata (rd_rec),
      .full  (fifo_full),
      .empty (fifo_empty),
      .level (level)
   );

   // Drain completes only once the buffer is empty and en stays low.
   always_comb begin
      state_d = state_q;
      done    = 1'b0;
      case (state_q)
         IDLE:  if (en) state_d = RUN;
         RUN:   if (!en) state_d = DRAIN;
         DRAIN: begin
            if (en) begin
               state_d = RUN;
            end else if (fifo_empty) begin
               state_d = IDLE;
               done    = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Dropped samples still consume a sequence number.
   always_comb begin
      time_d     = time_q + 1'b1;
      seq_d      = honour ? seq_q + 1'b1 : seq_q;
      overflow_d = overflow_q | drop;
      drop_cnt_d = drop_cnt_q;
      if (drop && (drop_cnt_q != '1)) begin
         drop_cnt_d = drop_cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= IDLE;
         time_q     <= '0;
         seq_q      <= '0;
         overflow_q <= 1'b0;
         drop_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         time_q     <= time_d;
         seq_q      <= seq_d;
         overflow_q <= overflow_d;
         drop_cnt_q <= drop_cnt_d;
      end
   end

   assign out_valid    = !fifo_empty;
   assign out_read     = rd_rec.read;
   assign out_exp      = rd_rec.exp;
   assign out_time     = rd_rec.time_stamp;
   assign out_seq      = rd_rec.seq;
   assign out_mismatch = rd_rec.mismatch;
   assign overflow     = overflow_q;
   assign drop_cnt     = drop_cnt_q;

endmodule

// File: tb/tb_ea_sample_capture.sv
// Bench for ea_sample_capture: directed scenarios plus a random soak, all
// checked each cycle against a queue-based record model.
`timescale 1ns/1ps
module tb_ea_sample_capture;

   localparam int DATA_W = 32;
   localparam int TIME_W = 64;
   localparam int DEPTH  = 16;
   localparam int SEQ_W  = 16;
   localparam int LVL_W  = 5;
   localparam int REC_W  = 2*DATA_W + TIME_W + SEQ_W + 1;

   localparam int M_IDLE  = 0;
   localparam int M_RUN   = 1;
   localparam int M_DRAIN = 2;

   logic              clk, reset, en, smp_valid, out_ready;
   logic [DATA_W-1:0] smp_read, smp_exp, out_read, out_exp;
   logic [TIME_W-1:0] out_time;
   logic [SEQ_W-1:0]  out_seq;
   logic              out_valid, out_mismatch, overflow, done;
   logic [LVL_W-1:0]  level;
   logic [15:0]       drop_cnt;

   ea_sample_capture dut (
      .clk          (clk),
      .reset        (reset),
      .en           (en),
      .smp_valid    (smp_valid),
      .smp_read     (smp_read),
      .smp_exp      (smp_exp),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .out_read     (out_read),
      .out_exp      (out_exp),
      .out_time     (out_time),
      .out_seq      (out_seq),
      .out_mismatch (out_mismatch),
      .level        (level),
      .overflow     (overflow),
      .drop_cnt     (drop_cnt),
      .done         (done)
   );

   // clock
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // scoreboard and reference state
   int                total = 0;
   int                bad   = 0;
   logic [REC_W-1:0]  exp_q[$];
   logic [TIME_W-1:0] m_time;
   logic [SEQ_W-1:0]  m_seq;
   logic              m_ovf;
   logic [15:0]       m_drops;
   int                m_mode;
   int                done_seen;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      total++;
      assert (obs === expv)
      else begin
         bad++;
         $display("FAIL %s: observed 0x%0h expected 0x%0h at %0t", tag, obs, expv, $time);
      end
   endtask

   // One clock: update the model from the inputs seen at the edge, then
   // compare every visible output against it away from the edge.
   task automatic step();
      int               n;
      bit               pop, keep;
      logic [REC_W-1:0] rec, h;
      @(posedge clk);
      if (reset) begin
         exp_q.delete();
         m_time  = '0;
         m_seq   = '0;
         m_ovf   = 1'b0;
         m_drops = '0;
         m_mode  = M_IDLE;
      end else begin
         n    = exp_q.size();
         pop  = (n > 0) && out_ready;
         keep = 1'b0;
         rec  = '0;
         if (m_mode == M_RUN && smp_valid) begin
            keep = 1'b1;
`ifdef EA_CAPTURE_MISMATCH_ONLY_EN
            keep = (smp_read != smp_exp);
`endif
            if (keep && n == DEPTH && !pop) begin
               keep  = 1'b0;
               m_ovf = 1'b1;
               if (m_drops != 16'hFFFF) m_drops++;
            end
            rec = {smp_read, smp_exp, m_time, m_seq, (smp_read != smp_exp)};
            m_seq++;
         end
         if (pop) void'(exp_q.pop_front());
         if (keep) exp_q.push_back(rec);
         case (m_mode)
            M_IDLE:  if (en) m_mode = M_RUN;
            M_RUN:   if (!en) m_mode = M_DRAIN;
            default: if (en) m_mode = M_RUN; else if (n == 0) m_mode = M_IDLE;
         endcase
         m_time++;
      end
      @(negedge clk);
      check("out_valid", out_valid, (exp_q.size() > 0));
      check("level", level, exp_q.size());
      check("overflow", overflow, m_ovf);
      check("drop_cnt", drop_cnt, m_drops);
      check("done", done, (m_mode == M_DRAIN && !en && exp_q.size() == 0));
      if (exp_q.size() > 0) begin
         h = exp_q[0];
         check("out_read", out_read, h[REC_W-1 -: DATA_W]);
         check("out_exp", out_exp, h[REC_W-DATA_W-1 -: DATA_W]);
         check("out_time", out_time, h[SEQ_W+1 +: TIME_W]);
         check("out_seq", out_seq, h[1 +: SEQ_W]);
         check("out_mismatch", out_mismatch, h[0]);
      end
      if (done) done_seen++;
   endtask

   task automatic drive_sample(input logic [DATA_W-1:0] rd, input logic [DATA_W-1:0] ex);
      smp_valid = 1'b1;
      smp_read  = rd;
      smp_exp   = ex;
      step();
      smp_valid = 1'b0;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      step();
      reset = 1'b0;
   endtask

   initial begin
      logic [DATA_W-1:0] r;
      reset = 1'b1; en = 1'b0; smp_valid = 1'b0; out_ready = 1'b0;
      smp_read = '0; smp_exp = '0; done_seen = 0;
      repeat (2) step();
      check("rst_out_read", out_read, 64'd0);
      check("rst_out_time", out_time, 64'd0);
      check("rst_done", done, 64'd0);

      // single sample captured at timestamp 10
      reset = 1'b0; en = 1'b1;
      for (int i = 0; i < 50 && m_time != 10; i++) step();
      drive_sample(32'h5, 32'h5);
`ifndef EA_CAPTURE_MISMATCH_ONLY_EN
      check("single_valid", out_valid, 64'd1);
      check("single_time", out_time, 64'd10);
      check("single_seq", out_seq, 64'd0);
      check("single_mismatch", out_mismatch, 64'd0);
`endif
      out_ready = 1'b1; step(); out_ready = 1'b0;

      // mismatch held under backpressure
      drive_sample(32'hA, 32'hB);
      repeat (5) step();
      check("bp_valid", out_valid, 64'd1);
      check("bp_mismatch", out_mismatch, 64'd1);
      check("bp_read", out_read, 64'hA);
      out_ready = 1'b1; step(); out_ready = 1'b0;
      check("bp_popped", level, 64'd0);

      // overflow: 20 samples into 16 slots
      do_reset(); step();
      for (int i = 0; i < 20; i++) begin
         r = $urandom;
         drive_sample(r, ~r);
      end
      check("ovf_level", level, 64'd16);
      check("ovf_flag", overflow, 64'd1);
      check("ovf_drops", drop_cnt, 64'd4);
      out_ready = 1'b1;
      for (int i = 0; i < 16; i++) begin
         check("drain_seq", out_seq, i);
         step();
      end
      out_ready = 1'b0;

      // full with simultaneous push and pop
      for (int i = 0; i < 16; i++) begin
         r = $urandom;
         drive_sample(r, ~r);
      end
      out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         r = $urandom;
         drive_sample(r, ~r);
      end
      out_ready = 1'b0;
      check("pp_level", level, 64'd16);
      check("pp_drops", drop_cnt, 64'd4);

      // stop and drain with three buffered samples
      do_reset(); step();
      for (int i = 0; i < 3; i++) begin
         r = $urandom;
         drive_sample(r, r ^ 32'h1);
      end
      en = 1'b0; step();
      done_seen = 0;
      for (int i = 0; i < 2; i++) begin
         r = $urandom;
         smp_valid = 1'($urandom_range(0, 1)); smp_read = r; smp_exp = ~r;
         step();
      end
      check("stop_ignored", level, 64'd3);
      out_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         smp_valid = 1'($urandom_range(0, 1)); smp_read = $urandom; smp_exp = $urandom;
         step();
      end
      smp_valid = 1'b0; out_ready = 1'b0;
      check("done_once", done_seen, 64'd1);

      // reset in the middle of a drain
      en = 1'b1; do_reset(); step();
      for (int i = 0; i < 5; i++) begin
         r = $urandom;
         drive_sample(r, ~r);
      end
      en = 1'b0; step();
      check("mid_level", level, 64'd5);
      do_reset();
      check("mid_valid", out_valid, 64'd0);
      check("mid_level0", level, 64'd0);
      check("mid_ovf", overflow, 64'd0);
      en = 1'b1; step();
      drive_sample(32'h3, 32'h4);
      check("mid_seq0", out_seq, 64'd0);

`ifdef EA_CAPTURE_MISMATCH_ONLY_EN
      do_reset(); step();
      drive_sample(32'd1, 32'd1);
      drive_sample(32'd2, 32'd3);
      drive_sample(32'd4, 32'd4);
      drive_sample(32'd5, 32'd6);
      check("mmo_level", level, 64'd2);
      check("mmo_seq1", out_seq, 64'd1);
      out_ready = 1'b1; step(); out_ready = 1'b0;
      check("mmo_seq3", out_seq, 64'd3);
`endif

      // random soak
      for (int i = 0; i < 600; i++) begin
         reset     = ($urandom_range(0, 149) == 0);
         en        = ($urandom_range(0, 9) != 0);
         smp_valid = 1'($urandom_range(0, 1));
         smp_read  = $urandom;
         smp_exp   = ($urandom_range(0, 1) != 0) ? smp_read : 32'($urandom);
         out_ready = ($urandom_range(0, 3) == 0);
         step();
      end
      reset = 1'b0; smp_valid = 1'b0;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/ea_sample_capture.md
Name: ea_sample_capture

Overview:
- Synthesizable consumer-side counterpart to the Error Analyzer DPI sample interface.
- Captures read/expected data pairs from DUT-side checkers and stamps each with a cycle-count timestamp and sequence number.
- Buffers samples in a FIFO and streams them out over valid/ready to the testbench drain, which forwards each record to the analyzer.
- Provides a controlled stop/drain handshake so final analysis only starts once every captured sample has been delivered.

Parameters:
- DATA_W, 32: width of read and expected data; 1..32, matching the int sample argument.
- TIME_W, 64: timestamp width, matching the longint time argument.
- DEPTH, 16: FIFO entries; power of two, >=2.
- SEQ_W, 16: sequence number width.

Ports:
- clk  in  1  single clock
- reset  in  1  synchronous, active-high reset
- en  in  1  capture enable; a falling edge requests stop and drain
- smp_valid  in  1  sample strobe, one sample per cycle
- smp_read  in  DATA_W  data read from the DUT
- smp_exp  in  DATA_W  expected data
- out_valid  out  1  output record available
- out_ready  in  1  consumer accepts the record
- out_read  out  DATA_W  record read data
- out_exp  out  DATA_W  record expected data
- out_time  out  TIME_W  record timestamp
- out_seq  out  SEQ_W  record sequence number
- out_mismatch  out  1  record read != expected
- level  out  $clog2(DEPTH)+1  FIFO occupancy
- overflow  out  1  sticky; at least one sample dropped
- drop_cnt  out  16  saturating count of dropped samples
- done  out  1  one-cycle pulse when drain completes

Behaviour:
- Reset is synchronous and active-high; all state is clocked on clk.
- Reset values: out_valid=0, level=0, overflow=0, drop_cnt=0, done=0, timestamp=0, seq=0, FSM=IDLE. Data outputs are 0.
- Reset mid-operation discards FIFO contents; out_valid=0 on the cycle after reset is sampled.
- Timestamp: free-running TIME_W cycle counter, incremented every non-reset cycle, wraps modulo 2^TIME_W. A sample records the counter value of the cycle in which smp_valid is high.
- Mismatch: computed combinationally at capture as smp_read != smp_exp, then stored with the record.
- FSM states: IDLE, RUN, DRAIN.
  - IDLE -> RUN when en=1.
  - RUN -> DRAIN when en=0.
  - DRAIN -> IDLE when the FIFO is empty and no pop is pending; done pulses on that transition cycle.
  - DRAIN -> RUN if en reasserts; no done pulse in that case.
- Capture: smp_valid is honoured only in RUN. In IDLE and DRAIN it is ignored: no seq increment, no drop.
- Sequence numbers: every honoured sample consumes one seq value, including dropped ones, so the consumer sees gaps. Wraps (2^SEQ_W-1) -> 0.
- FIFO is first-word-fall-through.
  - out_valid = !empty; outputs present the head entry.
  - A pop occurs when out_valid && out_ready.
  - Outputs are stable while out_valid && !out_ready.
- Capture latency: a sample pushed into an empty FIFO appears on out_valid the next cycle.
- Full FIFO: a push with a simultaneous pop is accepted and level is unchanged. A push without a pop is dropped, sets overflow, and increments drop_cnt (saturates at 16'hFFFF).
- Empty FIFO: out_ready is ignored; level never underflows.
- overflow and drop_cnt clear only on reset.

Optional Feature:
- Macro: EA_CAPTURE_MISMATCH_ONLY_EN.
- Defined: samples with read == exp are not pushed into the FIFO and never count as drops, but still consume a seq number. out_mismatch is therefore always 1.
- Undefined: every honoured sample is pushed.

Decomposition:
- Package ea_capture_pkg:
  - typedef struct packed ea_sample_t {read, exp, time, seq, mismatch}, parameterized via package localparams.
  - typedef enum ea_cap_state_e {IDLE, RUN, DRAIN}.
  - localparam DROP_CNT_W=16.
- Sub-module ea_sample_fifo: generic FWFT FIFO of ea_sample_t with push/pop/full/empty/level, sized by DEPTH, same clk/reset.
- Top level contains only the FSM, timestamp and seq counters, mismatch compare and drop accounting.

Test Plan:
- Single sample: reset, en=1, smp_valid at timestamp 10 with read=0x5, exp=0x5 -> next cycle out_valid=1, out_time=10, out_seq=0, out_mismatch=0.
- Mismatch with backpressure: read=0xA, exp=0xB, out_ready=0 for 5 cycles -> record held stable with out_mismatch=1; popped on the first cycle out_ready=1.
- Overflow, DEPTH=16, out_ready=0: 20 back-to-back samples -> level=16, overflow=1, drop_cnt=4. Then drain with out_ready=1 -> seq 0..15 delivered.
- Full with simultaneous push and pop: FIFO full, smp_valid and out_ready both high for 3 cycles -> drop_cnt unchanged, level stays 16.
- Stop and drain: 3 samples buffered, en->0 -> smp_valid ignored; done pulses exactly once, on the cycle the FSM returns to IDLE after the 3rd pop.
- Reset mid-drain with level=5 -> out_valid=0, level=0, overflow=0 the next cycle, and the next sample gets seq=0.
- With EA_CAPTURE_MISMATCH_ONLY_EN: inputs (read, exp) = (1,1), (2,3), (4,4), (5,6) -> 2 records, seq 1 and 3.
